// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, one stop bit, with a one-entry
// output register, valid/ready handshake and single-cycle error pulses.
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 rx_clk_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  state_t               state;
  state_t               state_nxt;
  logic [3:0]           tick_cnt;
  logic [3:0]           tick_nxt;
  logic [3:0]           bit_cnt;
  logic [3:0]           bit_nxt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_nxt;
  logic                 rxd_meta;
  logic                 rxd_s;
  logic                 stop_ok;
  logic                 stop_bad;

  // Two-flop synchroniser for the asynchronous line; resets to the idle level.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // Frame FSM state, oversample counters and data shift register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
    end
  end

  // Next-state logic; everything advances only on oversample ticks.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    if (rx_clk_en) begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state_nxt = START;
            tick_nxt  = '0;
          end
        end
        START: begin
          if (tick_cnt == 4'd7) begin
            if (!rxd_s) begin
              state_nxt = DATA;
              tick_nxt  = '0;
              bit_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            tick_nxt = tick_cnt + 4'd1;
          end
        end
        DATA: begin
          tick_nxt = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            shift_nxt = {rxd_s, shift_reg[DATA_BITS-1:1]};
            bit_nxt   = bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              state_nxt = STOP;
            end
          end
        end
        STOP: begin
          tick_nxt = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            if (rxd_s) begin
              stop_ok   = 1'b1;
              state_nxt = IDLE;
            end else begin
              stop_bad  = 1'b1;
              state_nxt = WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rxd_s) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output register: delivery, overrun dropping, handshake and error pulses.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (stop_ok) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with a 4-clock oversample strobe (64 clk per bit).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       rx_clk_en;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int         div_cnt = 0;
  int         errors = 0;
  int         checks = 0;
  int         valid_rises = 0;
  int         fe_cycles = 0;
  int         ov_cycles = 0;
  logic       prev_valid = 1'b0;
  logic       pre_valid = 1'b0;
  logic       stop_valid = 1'b0;
  logic [7:0] pre_data = 8'h00;
  logic [7:0] stop_data = 8'h00;
  int         base_rises;
  int         base_fe;
  int         base_ov;

  uart_rx #(.DATA_BITS(8)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .rx_clk_en (rx_clk_en),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Free-running oversample strobe: one clk in four.
  always @(posedge clk) begin
    div_cnt <= (div_cnt == 3) ? 0 : div_cnt + 1;
  end
  assign rx_clk_en = (div_cnt == 3);

  // Event counters for valid rising edges and high cycles of the pulse outputs.
  always @(negedge clk) begin
    if (!rstb) begin
      prev_valid <= 1'b0;
    end else begin
      if (rx_valid && !prev_valid) valid_rises <= valid_rises + 1;
      if (frame_err) fe_cycles <= fe_cycles + 1;
      if (overrun) ov_cycles <= ov_cycles + 1;
      prev_valid <= rx_valid;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic snapshot();
    base_rises = valid_rises;
    base_fe    = fe_cycles;
    base_ov    = ov_cycles;
  endtask

  // Sends one frame aligned so the start edge is seen on a tick; the stop
  // sample then lands on the edge just before negedge 611 of the frame.
  task automatic applyStimulus(input logic [7:0] frame_byte, input logic stop_bit,
                               input int ready_at);
    logic [9:0] bits;
    bits = {stop_bit, frame_byte, 1'b0};
    while (div_cnt != 1) @(negedge clk);
    for (int t = 0; t < 640; t++) begin
      rxd = bits[t/64];
      if (ready_at >= 0) begin
        if (t == ready_at) rx_ready = 1'b1;
        else if (t == ready_at + 1) rx_ready = 1'b0;
      end
      if (t == 610) begin
        pre_valid = rx_valid;
        pre_data  = rx_data;
      end
      if (t == 611) begin
        stop_valid = rx_valid;
        stop_data  = rx_data;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", 32'(rx_valid), 32'h0);
    checkOutput("reset_data", 32'(rx_data), 32'h0);
    checkOutput("reset_ferr", 32'(frame_err), 32'h0);
    checkOutput("reset_ovr", 32'(overrun), 32'h0);
    rstb = 1'b1;
    repeat (20) @(negedge clk);

    $display("[TB] single frame 0xA5");
    rx_ready = 1'b1;
    snapshot();
    applyStimulus(8'hA5, 1'b1, -1);
    checkOutput("a5_pre_valid", 32'(pre_valid), 32'h0);
    checkOutput("a5_stop_valid", 32'(stop_valid), 32'h1);
    checkOutput("a5_data", 32'(stop_data), 32'hA5);
    checkOutput("a5_accepted", 32'(rx_valid), 32'h0);
    checkOutput("a5_rises", 32'(valid_rises - base_rises), 32'h1);
    checkOutput("a5_ferr", 32'(fe_cycles - base_fe), 32'h0);
    checkOutput("a5_ovr", 32'(ov_cycles - base_ov), 32'h0);

    $display("[TB] back-to-back 0x3C 0xC3 without ready");
    rx_ready = 1'b0;
    snapshot();
    applyStimulus(8'h3C, 1'b1, -1);
    applyStimulus(8'hC3, 1'b1, -1);
    checkOutput("ovr_valid", 32'(rx_valid), 32'h1);
    checkOutput("ovr_data", 32'(rx_data), 32'h3C);
    checkOutput("ovr_pulses", 32'(ov_cycles - base_ov), 32'h1);
    checkOutput("ovr_rises", 32'(valid_rises - base_rises), 32'h1);
    rx_ready = 1'b1;
    @(negedge clk);
    checkOutput("ovr_accept_valid", 32'(rx_valid), 32'h0);
    checkOutput("ovr_accept_data", 32'(rx_data), 32'h3C);

    $display("[TB] bad stop bit then held break");
    snapshot();
    applyStimulus(8'h55, 1'b0, -1);
    rxd = 1'b0;
    repeat (2560) @(negedge clk);
    rxd = 1'b1;
    repeat (128) @(negedge clk);
    checkOutput("brk_ferr_pulses", 32'(fe_cycles - base_fe), 32'h1);
    checkOutput("brk_rises", 32'(valid_rises - base_rises), 32'h0);
    checkOutput("brk_valid", 32'(rx_valid), 32'h0);
    applyStimulus(8'h12, 1'b1, -1);
    checkOutput("brk_next_valid", 32'(stop_valid), 32'h1);
    checkOutput("brk_next_data", 32'(stop_data), 32'h12);

    $display("[TB] start glitch of 5 ticks");
    snapshot();
    while (div_cnt != 1) @(negedge clk);
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (128) @(negedge clk);
    checkOutput("glitch_rises", 32'(valid_rises - base_rises), 32'h0);
    checkOutput("glitch_ferr", 32'(fe_cycles - base_fe), 32'h0);
    checkOutput("glitch_ovr", 32'(ov_cycles - base_ov), 32'h0);
    applyStimulus(8'h81, 1'b1, -1);
    checkOutput("glitch_next_data", 32'(stop_data), 32'h81);
    checkOutput("glitch_next_valid", 32'(stop_valid), 32'h1);

    $display("[TB] accept and deliver on the same edge");
    rx_ready = 1'b0;
    snapshot();
    applyStimulus(8'h11, 1'b1, -1);
    checkOutput("hold_data", 32'(rx_data), 32'h11);
    applyStimulus(8'h22, 1'b1, 610);
    checkOutput("same_pre_data", 32'(pre_data), 32'h11);
    checkOutput("same_pre_valid", 32'(pre_valid), 32'h1);
    checkOutput("same_valid", 32'(stop_valid), 32'h1);
    checkOutput("same_data", 32'(stop_data), 32'h22);
    checkOutput("same_ovr", 32'(ov_cycles - base_ov), 32'h0);
    checkOutput("same_still_valid", 32'(rx_valid), 32'h1);

    $display("[TB] reset in the middle of 0xFF");
    while (div_cnt != 1) @(negedge clk);
    rxd = 1'b0;
    repeat (64) @(negedge clk);
    rxd = 1'b1;
    repeat (64 * 4 + 32) @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_valid", 32'(rx_valid), 32'h0);
    checkOutput("mid_rst_data", 32'(rx_data), 32'h0);
    checkOutput("mid_rst_ferr", 32'(frame_err), 32'h0);
    checkOutput("mid_rst_ovr", 32'(overrun), 32'h0);
    repeat (4) @(negedge clk);
    rstb = 1'b1;
    repeat (128) @(negedge clk);
    rx_ready = 1'b1;
    snapshot();
    applyStimulus(8'h0F, 1'b1, -1);
    checkOutput("post_rst_pre_valid", 32'(pre_valid), 32'h0);
    checkOutput("post_rst_valid", 32'(stop_valid), 32'h1);
    checkOutput("post_rst_data", 32'(stop_data), 32'h0F);
    checkOutput("post_rst_ferr", 32'(fe_cycles - base_fe), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
